// File: rtl/leb128_decoder_if.sv
// Handshake bundle for the LEB128 immediate decoder: control, byte stream in, decoded result out.
interface leb128_decoder_if;
    logic        start;
    logic        signed_mode;
    logic        is64;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] out_value;
    logic [3:0]  out_len;
    logic        out_valid;
    logic        out_ready;
    logic        error;
    logic        busy;

    modport master (
        output start, signed_mode, is64, in_data, in_valid, out_ready,
        input  in_ready, out_value, out_len, out_valid, error, busy
    );

    modport slave (
        input  start, signed_mode, is64, in_data, in_valid, out_ready,
        output in_ready, out_value, out_len, out_valid, error, busy
    );
endinterface

// File: rtl/leb128_decoder.sv
// Byte-serial LEB128 decoder (signed/unsigned, i32/i64) with overlong-encoding detection.
module leb128_decoder (
    input  logic            clk,
    input  logic            reset,
    leb128_decoder_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ACCUM, DONE, ERR} state_t;

    state_t      state, state_nx;
    logic [63:0] acc, acc_nx, ext, res;
    logic [63:0] val_q;
    logic [3:0]  cnt, len_q;
    logic [6:0]  shamt;
    logic        sgn_q, is64_q;
    logic        load, take, last, at_max;
    logic        in_ready_c, out_valid_c, error_c;

    assign take   = in_ready_c && bus.in_valid;
    assign last   = !bus.in_data[7];
    assign at_max = (cnt == (is64_q ? 4'd9 : 4'd4));

    always_comb begin
        state_nx    = state;
        in_ready_c  = 1'b0;
        out_valid_c = 1'b0;
        error_c     = 1'b0;
        load        = 1'b0;
        case (state)
            IDLE: if (bus.start) begin
                state_nx = ACCUM;
                load     = 1'b1;
            end
            ACCUM: begin
                in_ready_c = 1'b1;
                if (bus.in_valid) begin
                    if (last)        state_nx = DONE;
                    else if (at_max) state_nx = ERR;
                end
            end
            DONE: begin
                out_valid_c = 1'b1;
                if (bus.out_ready) begin
                    if (bus.start) begin
                        state_nx = ACCUM;
                        load     = 1'b1;
                    end else begin
                        state_nx = IDLE;
                    end
                end
            end
            ERR: begin
                error_c = 1'b1;
                if (bus.start) begin
                    state_nx = ACCUM;
                    load     = 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Shifting by >= 64 yields zero, so payload bits past bit 63 fall away naturally.
    always_comb begin
        shamt  = 7'(cnt) * 7'd7;
        acc_nx = acc | ({57'd0, bus.in_data[6:0]} << shamt);
        ext    = acc_nx;
        if (sgn_q && bus.in_data[6])
            ext = acc_nx | (~64'd0 << (shamt + 7'd7));
        if (is64_q)
            res = ext;
        else if (sgn_q)
            res = {{32{ext[31]}}, ext[31:0]};
        else
            res = {32'd0, ext[31:0]};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            acc    <= '0;
            cnt    <= '0;
            sgn_q  <= 1'b0;
            is64_q <= 1'b0;
            val_q  <= '0;
            len_q  <= '0;
        end else begin
            state <= state_nx;
            if (load) begin
                acc    <= '0;
                cnt    <= '0;
                sgn_q  <= bus.signed_mode;
                is64_q <= bus.is64;
            end else if (take) begin
                acc <= acc_nx;
                cnt <= cnt + 4'd1;
                if (last) begin
                    val_q <= res;
                    len_q <= cnt + 4'd1;
                end
            end
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_c;
    assign bus.error     = error_c;
    assign bus.busy      = (state != IDLE);
    assign bus.out_value = val_q;
    assign bus.out_len   = len_q;
endmodule

// File: doc/leb128_decoder.md
LEB128_DECODER -- requirements
Module: leb128_decoder

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port start, input, 1 bit: begin a new decode when idle.
REQ-004 SHALL have port signed_mode, input, 1 bit: 1 selects signed LEB128, 0 unsigned; sampled with start.
REQ-005 SHALL have port is64, input, 1 bit: 1 selects i64 (max 10 bytes), 0 selects i32 (max 5 bytes); sampled with start.
REQ-006 SHALL have port in_data, input, 8 bits: byte from the instruction stream.
REQ-007 SHALL have port in_valid, input, 1 bit: in_data is valid.
REQ-008 SHALL have port in_ready, output, 1 bit: decoder accepts a byte this cycle.
REQ-009 SHALL have port out_value, output, 64 bits: decoded immediate.
REQ-010 SHALL have port out_len, output, 4 bits: bytes consumed by the decode, 1..10.
REQ-011 SHALL have port out_valid, output, 1 bit: out_value and out_len are valid.
REQ-012 SHALL have port out_ready, input, 1 bit: consumer (cpu operand stage) accepts the result.
REQ-013 SHALL have port error, output, 1 bit: overlong encoding detected.
REQ-014 SHALL have port busy, output, 1 bit: high in every state except IDLE.

Function
REQ-015 SHALL implement states IDLE, ACCUM, DONE, ERR.
REQ-016 SHALL go IDLE->ACCUM on start=1, latching signed_mode and is64 and clearing accumulator, shift count and byte count.
REQ-017 SHALL assert in_ready only in ACCUM; a byte is consumed when in_valid && in_ready.
REQ-018 SHALL OR bits [6:0] of each consumed byte into the accumulator at bit offset 7*n, where n is the zero-based byte index; bits beyond 63 are discarded.
REQ-019 SHALL treat a byte with bit7=0 as final: ACCUM->DONE on the next edge, with out_valid=1 in the cycle following the final byte's acceptance (1-cycle latency).
REQ-020 SHALL, in signed mode, sign-extend from bit 7*(n+1)-1 when bit6 of the final byte is 1, filling all higher bits with 1.
REQ-021 SHALL, when is64=0, produce a 32-bit result: unsigned zero-extends bit 31 to bit 63; signed sign-extends bit 31 to bit 63.
REQ-022 SHALL ignore unused high bits of the final byte; no error is raised for them.
REQ-023 SHALL, when the maximum byte count (5 or 10) is consumed with bit7=1 on the last byte, go ACCUM->ERR; no out_valid is produced.
REQ-024 SHALL hold error=1 in ERR until start=1 (ERR->ACCUM) or reset.
REQ-025 SHALL hold out_value, out_len and out_valid stable in DONE while out_ready=0.
REQ-026 SHALL, on out_valid && out_ready, go DONE->IDLE; if start=1 in that same cycle, go directly DONE->ACCUM for a back-to-back decode.
REQ-027 SHALL ignore start in ACCUM; the decode in progress continues unaffected.
REQ-028 SHALL stall in ACCUM indefinitely while in_valid=0, with no timeout.

Reset
REQ-029 SHALL, on reset=0, immediately force state to IDLE and set in_ready=0, out_valid=0, error=0, busy=0, out_value=0 and out_len=0, regardless of clock.
REQ-030 SHALL abandon a decode interrupted by reset; no partial result appears after reset is released.
REQ-031 SHALL start no decode until the first start=1 after reset is released.

Verification
REQ-032 SHALL pass: unsigned, is64=1, bytes E5 8E 26 -> out_value=0x0000_0000_0009_8765 (624485), out_len=3, out_valid one cycle after byte 26.
REQ-033 SHALL pass: signed, is64=1, bytes C0 BB 78 -> out_value=0xFFFF_FFFF_FFFE_1DC0 (-123456), out_len=3.
REQ-034 SHALL pass: signed, is64=0, byte 7F -> out_value=0xFFFF_FFFF_FFFF_FFFF, out_len=1; unsigned, is64=0, bytes FF FF FF FF 0F -> out_value=0x0000_0000_FFFF_FFFF, out_len=5.
REQ-035 SHALL pass: is64=0, bytes 80 80 80 80 80 -> error=1 after the 5th byte, out_valid never asserted; start then clears error.
REQ-036 SHALL pass: out_ready held at 0 for 5 cycles -> out_value and out_len stable throughout; out_ready=1 together with start=1 -> next decode accepts its first byte in the following cycle.
REQ-037 SHALL pass: reset=0 asserted after byte 2 of a 3-byte decode -> all outputs are 0 immediately; after release, out_valid stays 0 until a new start and decode.
